scnn_coord_gen: RTL and testbench

//  Pipelined, parametrised output-coordinate generator for the SCNN PE multiplier array.
//  Per vector: rebuilds original weight/input indices from zero-run compressed indices,

---
 rtl/scnn_pkg.sv | 35 +++
 rtl/scnn_idx_divmod.sv | 19 +
 rtl/scnn_coord_gen.sv | 177 +++++++++++++++++
 tb/tb_scnn_coord_gen.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scnn_pkg.sv
// Shared sizes and types for the SCNN output-coordinate generator.
package scnn_pkg;
    localparam int F      = 4;
    localparam int I      = 4;
    localparam int P      = F * I;
    localparam int IDXW   = 8;
    localparam int CORDW  = 8;
    localparam int WT_MAX = 5;
    localparam int IP_MAX = 16;
    localparam int OW     = IDXW + 2;
    localparam int WCW    = $clog2(F + 1);
    localparam int ICW    = $clog2(I + 1);
    localparam int WSW    = 4;
    localparam int IPW    = 8;
    localparam int WQW    = $clog2(WT_MAX);
    localparam int IQW    = $clog2(IP_MAX);

    typedef logic [IDXW-1:0]  idx_t;
    typedef logic [CORDW-1:0] cord_t;
    typedef logic [OW-1:0]    oidx_t;

    localparam cord_t INVALID_CORD = '1;
    localparam idx_t  IDX_MAX      = '1;

    typedef struct packed {
        cord_t [P-1:0] coord;
        logic  [P-1:0] mask;
        idx_t          last_wt;
        idx_t          last_ip;
    } s2_pay_t;

    function automatic idx_t sat_idx(input oidx_t v);
        return (v > oidx_t'(IDX_MAX)) ? IDX_MAX : idx_t'(v);
    endfunction
endpackage

// File: rtl/scnn_idx_divmod.sv
// Bounded quotient/remainder by compare chain; valid while x < MAX*d.
module scnn_idx_divmod #(
    parameter int XW  = 10,
    parameter int DW  = 8,
    parameter int MAX = 16,
    parameter int QW  = $clog2(MAX)
) (
    input  logic [XW-1:0] x,
    input  logic [DW-1:0] d,
    output logic [QW-1:0] q,
    output logic [DW-1:0] r
);
    always_comb begin
        q = '0;
        for (int k = 1; k < MAX; k++)
            if (int'(x) >= k * int'(d)) q = QW'(k);
        r = DW'(int'(x) - int'(q) * int'(d));
    end
endmodule

// File: rtl/scnn_coord_gen.sv
// Rebuilds original weight/input indices from zero-run counts, then emits the
// F x I output coordinates with a per-product valid mask (2-stage pipeline).
module scnn_coord_gen
    import scnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WSW-1:0]          cfg_wt_size,
    input  logic [IPW-1:0]          cfg_ip_size,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_first,
    input  logic [WCW-1:0]          in_wt_cnt,
    input  logic [ICW-1:0]          in_ip_cnt,
    input  logic [F-1:0][IDXW-1:0]  in_comp_wt,
    input  logic [I-1:0][IDXW-1:0]  in_comp_ip,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [P-1:0][CORDW-1:0] out_coord,
    output logic [P-1:0]            out_mask,
    output logic [IDXW-1:0]         out_last_wt,
    output logic [IDXW-1:0]         out_last_ip,
    output logic                    err_ovf
);
    logic s1_valid, s2_valid, s1_adv, accept;

    assign s1_adv   = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s1_adv;
    assign accept   = in_valid && in_ready;

    // ---------------- S1: index reconstruction ----------------
    idx_t          base_wt, base_ip, b_wt, b_ip, nb_wt, nb_ip, last_wt_d, last_ip_d;
    oidx_t [F-1:0] orig_wt;
    oidx_t [I-1:0] orig_ip;
    oidx_t         acc_w, acc_i, sel_w, sel_i;

    always_comb begin
        b_wt  = in_first ? '0 : base_wt;
        b_ip  = in_first ? '0 : base_ip;
        acc_w = oidx_t'(b_wt);
        acc_i = oidx_t'(b_ip);
        sel_w = '0;
        sel_i = '0;
        for (int k = 0; k < F; k++) begin
            acc_w      = acc_w + oidx_t'(in_comp_wt[k]) + ((k == 0) ? oidx_t'(0) : oidx_t'(1));
            orig_wt[k] = acc_w;
            if (WCW'(k + 1) == in_wt_cnt) sel_w = acc_w;
        end
        for (int k = 0; k < I; k++) begin
            acc_i      = acc_i + oidx_t'(in_comp_ip[k]) + ((k == 0) ? oidx_t'(0) : oidx_t'(1));
            orig_ip[k] = acc_i;
            if (ICW'(k + 1) == in_ip_cnt) sel_i = acc_i;
        end
        // An empty side keeps its running base and reports the index just before it.
        if (in_wt_cnt == '0) begin
            nb_wt     = base_wt;
            last_wt_d = (b_wt == '0) ? '0 : b_wt - 1'b1;
        end else begin
            nb_wt     = (sel_w >= oidx_t'(IDX_MAX)) ? IDX_MAX : idx_t'(sel_w + 1'b1);
            last_wt_d = sat_idx(sel_w);
        end
        if (in_ip_cnt == '0) begin
            nb_ip     = base_ip;
            last_ip_d = (b_ip == '0) ? '0 : b_ip - 1'b1;
        end else begin
            nb_ip     = (sel_i >= oidx_t'(IDX_MAX)) ? IDX_MAX : idx_t'(sel_i + 1'b1);
            last_ip_d = sat_idx(sel_i);
        end
    end

    oidx_t [F-1:0]  s1_wt;
    oidx_t [I-1:0]  s1_ip;
    logic [WCW-1:0] s1_wt_cnt;
    logic [ICW-1:0] s1_ip_cnt;
    idx_t           s1_last_wt, s1_last_ip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            base_wt    <= '0;
            base_ip    <= '0;
            s1_wt      <= '0;
            s1_ip      <= '0;
            s1_wt_cnt  <= '0;
            s1_ip_cnt  <= '0;
            s1_last_wt <= '0;
            s1_last_ip <= '0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            base_wt    <= nb_wt;
            base_ip    <= nb_ip;
            s1_wt      <= orig_wt;
            s1_ip      <= orig_ip;
            s1_wt_cnt  <= in_wt_cnt;
            s1_ip_cnt  <= in_ip_cnt;
            s1_last_wt <= last_wt_d;
            s1_last_ip <= last_ip_d;
        end else if (s1_adv) begin
            s1_valid   <= 1'b0;
        end
    end

    // ---------------- S2: row/col split and output coordinates ----------------
    logic [F-1:0][WQW-1:0] wr;
    logic [F-1:0][WSW-1:0] wcol;
    logic [I-1:0][IQW-1:0] ir;
    logic [I-1:0][IPW-1:0] icol;

    for (genvar f = 0; f < F; f++) begin : g_wt
        scnn_idx_divmod #(.XW(OW), .DW(WSW), .MAX(WT_MAX), .QW(WQW)) u_dm (
            .x(s1_wt[f]), .d(cfg_wt_size), .q(wr[f]), .r(wcol[f])
        );
    end
    for (genvar i = 0; i < I; i++) begin : g_ip
        scnn_idx_divmod #(.XW(OW), .DW(IPW), .MAX(IP_MAX), .QW(IQW)) u_dm (
            .x(s1_ip[i]), .d(cfg_ip_size), .q(ir[i]), .r(icol[i])
        );
    end

    s2_pay_t s2_d, s2_q;
    logic [F-1:0] wt_ok;
    logic [I-1:0] ip_ok;
    logic         ovf, live;
    int           ws, ips, cen, orow, ocol;

    always_comb begin
        s2_d  = '0;
        wt_ok = '0;
        ip_ok = '0;
        ovf   = 1'b0;
        live  = 1'b0;
        orow  = 0;
        ocol  = 0;
        ws    = int'(cfg_wt_size);
        ips   = int'(cfg_ip_size);
        cen   = (ws - 1) / 2;
        for (int f = 0; f < F; f++) begin
            wt_ok[f] = int'(s1_wt[f]) < ws * ws;
            if (WCW'(f) < s1_wt_cnt && !wt_ok[f]) ovf = 1'b1;
        end
        for (int i = 0; i < I; i++) begin
            ip_ok[i] = int'(s1_ip[i]) < ips * ips;
            if (ICW'(i) < s1_ip_cnt && !ip_ok[i]) ovf = 1'b1;
        end
        for (int f = 0; f < F; f++) begin
            for (int i = 0; i < I; i++) begin
                orow = int'(ir[i]) + cen - int'(wr[f]);
                ocol = int'(icol[i]) + cen - int'(wcol[f]);
                live = (WCW'(f) < s1_wt_cnt) && (ICW'(i) < s1_ip_cnt) && wt_ok[f] && ip_ok[i];
                s2_d.mask[f*I+i]  = live && orow >= 0 && orow < ips && ocol >= 0 && ocol < ips;
                s2_d.coord[f*I+i] = s2_d.mask[f*I+i] ? cord_t'(orow * ips + ocol) : INVALID_CORD;
            end
        end
        s2_d.last_wt = s1_last_wt;
        s2_d.last_ip = s1_last_ip;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
            err_ovf  <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q    <= s2_d;
                err_ovf <= err_ovf | ovf;
            end
        end
    end

    assign out_valid   = s2_valid;
    assign out_coord   = s2_q.coord;
    assign out_mask    = s2_q.mask;
    assign out_last_wt = s2_q.last_wt;
    assign out_last_ip = s2_q.last_ip;
endmodule

// File: tb/tb_scnn_coord_gen.sv
// Randomized and directed bench for scnn_coord_gen against an arithmetic reference model.
module tb_scnn_coord_gen;
    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       cfg_wt_size;
    logic [7:0]       cfg_ip_size;
    logic             in_valid, in_ready, in_first;
    logic [2:0]       in_wt_cnt, in_ip_cnt;
    logic [3:0][7:0]  in_comp_wt, in_comp_ip;
    logic             out_valid, out_ready;
    logic [15:0][7:0] out_coord;
    logic [15:0]      out_mask;
    logic [7:0]       out_last_wt, out_last_ip;
    logic             err_ovf;

    always #5 clk = ~clk;

    scnn_coord_gen dut (
        .clk(clk), .rst_n(rst_n), .cfg_wt_size(cfg_wt_size), .cfg_ip_size(cfg_ip_size),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
        .in_wt_cnt(in_wt_cnt), .in_ip_cnt(in_ip_cnt),
        .in_comp_wt(in_comp_wt), .in_comp_ip(in_comp_ip),
        .out_valid(out_valid), .out_ready(out_ready), .out_coord(out_coord),
        .out_mask(out_mask), .out_last_wt(out_last_wt), .out_last_ip(out_last_ip),
        .err_ovf(err_ovf)
    );

    typedef struct {
        logic [127:0] coord;
        logic [15:0]  mask;
        logic [7:0]   lw, li;
        logic         err;
    } exp_t;

    exp_t         q[$];
    int           checks = 0, errors = 0;
    int           acc_cnt = 0, emit_cnt = 0, cyc = 0, acc_cyc = 0, emit_cyc = 0;
    int           m_bw = 0, m_bi = 0;
    logic         m_err = 1'b0;
    logic [127:0] obs_coord;
    logic [15:0]  obs_mask;
    logic [7:0]   obs_lw, obs_li;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Reference: plain integer arithmetic over original indices and tile geometry.
    function automatic exp_t model(input logic first, input int wc, input int ic,
                                   input logic [3:0][7:0] cw, input logic [3:0][7:0] ci);
        exp_t e;
        int ow[4], oi[4];
        int ws, ips, cen, bw, bi, orow, ocol, p;
        logic live, bad;
        ws  = int'(cfg_wt_size);
        ips = int'(cfg_ip_size);
        cen = (ws - 1) / 2;
        bw  = first ? 0 : m_bw;
        bi  = first ? 0 : m_bi;
        for (int k = 0; k < 4; k++) begin
            ow[k] = (((k == 0) ? bw : ow[k-1] + 1) + int'(cw[k])) & 1023;
            oi[k] = (((k == 0) ? bi : oi[k-1] + 1) + int'(ci[k])) & 1023;
        end
        if (wc > 0) begin e.lw = 8'(min255(ow[wc-1])); m_bw = min255(ow[wc-1] + 1); end
        else e.lw = 8'((bw == 0) ? 0 : bw - 1);
        if (ic > 0) begin e.li = 8'(min255(oi[ic-1])); m_bi = min255(oi[ic-1] + 1); end
        else e.li = 8'((bi == 0) ? 0 : bi - 1);
        bad = 1'b0;
        e.mask = '0;
        for (int f = 0; f < 4; f++) begin
            if (f < wc && ow[f] >= ws * ws) bad = 1'b1;
            if (f < ic && oi[f] >= ips * ips) bad = 1'b1;
        end
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 4; i++) begin
                p    = f * 4 + i;
                live = f < wc && i < ic && ow[f] < ws * ws && oi[i] < ips * ips;
                orow = oi[i] / ips + cen - ow[f] / ws;
                ocol = oi[i] % ips + cen - ow[f] % ws;
                if (live && orow >= 0 && orow < ips && ocol >= 0 && ocol < ips) begin
                    e.mask[p] = 1'b1;
                    e.coord[p*8 +: 8] = 8'(orow * ips + ocol);
                end else begin
                    e.coord[p*8 +: 8] = 8'hFF;
                end
            end
        end
        m_err = m_err | bad;
        e.err = m_err;
        return e;
    endfunction

    // Monitor: samples 2ns after the negedge, well clear of the active edge.
    always @(negedge clk) begin
        cyc++;
        #2;
        if (rst_n) begin
            if (out_valid) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    chk("coord", out_coord, q[0].coord);
                    chk("mask", out_mask, q[0].mask);
                    chk("last_wt", out_last_wt, q[0].lw);
                    chk("last_ip", out_last_ip, q[0].li);
                    chk("err_ovf", err_ovf, q[0].err);
                    if (out_ready) begin
                        obs_coord = out_coord; obs_mask = out_mask;
                        obs_lw = out_last_wt; obs_li = out_last_ip;
                        void'(q.pop_front());
                        emit_cnt++;
                        emit_cyc = cyc;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_first, int'(in_wt_cnt), int'(in_ip_cnt), in_comp_wt, in_comp_ip));
                acc_cnt++;
                acc_cyc = cyc;
            end
        end
    end

    task automatic drive(input logic first, input int wc, input int ic,
                         input logic [3:0][7:0] cw, input logic [3:0][7:0] ci);
        in_valid = 1'b1; in_first = first;
        in_wt_cnt = 3'(wc); in_ip_cnt = 3'(ic);
        in_comp_wt = cw; in_comp_ip = ci;
    endtask

    task automatic wait_acc(input int n);
        for (int g = 0; g < 50 && acc_cnt == n; g++) @(negedge clk);
        chk("accept", 1'(acc_cnt != n), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_emit(input int target);
        for (int g = 0; g < 100 && emit_cnt < target; g++) @(negedge clk);
        chk("emit", 1'(emit_cnt >= target), 1);
    endtask

    task automatic send(input logic first, input int wc, input int ic,
                        input logic [3:0][7:0] cw, input logic [3:0][7:0] ci);
        int n, e;
        n = acc_cnt; e = emit_cnt;
        drive(first, wc, ic, cw, ci);
        wait_acc(n);
        wait_emit(e + 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int g = 0; g < 200 && q.size() != 0; g++) @(negedge clk);
        chk("drain", q.size(), 0);
    endtask

    task automatic rand_vec();
        logic [3:0][7:0] cw, ci;
        logic first;
        int wc, ic;
        first = 1'($urandom_range(0, 1));
        wc = $urandom_range(0, 4);
        ic = $urandom_range(0, 4);
        if (first && wc == 0) wc = 1;
        if (first && ic == 0) ic = 1;
        for (int k = 0; k < 4; k++) begin
            cw[k] = 8'($urandom_range(0, 2));
            ci[k] = 8'($urandom_range(0, 2));
        end
        drive(first, wc, ic, cw, ci);
    endtask

    task automatic rand_stream(input int nv);
        int sent, seen, g;
        sent = 0; seen = acc_cnt; g = 0;
        in_valid = 1'b0;
        while ((sent < nv || in_valid) && g < 3000) begin
            @(negedge clk);
            g++;
            out_ready = ($urandom_range(0, 99) < 70);
            if (in_valid && acc_cnt != seen) in_valid = 1'b0;
            if (!in_valid && sent < nv && $urandom_range(0, 3) != 0) begin
                rand_vec();
                sent++;
                seen = acc_cnt;
            end
        end
        chk("stream_done", 1'(g < 3000), 1);
        in_valid = 1'b0;
        drain();
    endtask

    logic [3:0][7:0] z, cw, ci;

    initial begin
        z = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; out_ready = 1'b1;
        in_wt_cnt = '0; in_ip_cnt = '0; in_comp_wt = '0; in_comp_ip = '0;
        cfg_wt_size = 4'd3; cfg_ip_size = 8'd4;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_coord", out_coord, 0);
        chk("rst_mask", out_mask, 0);
        chk("rst_last_wt", out_last_wt, 0);
        chk("rst_last_ip", out_last_ip, 0);
        chk("rst_err", err_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // First vector of a tile: orig 0..3 on both sides.
        send(1'b1, 4, 4, z, z);
        chk("t1_p0", obs_coord[7:0], 8'd5);
        chk("t1_p4", obs_coord[39:32], 8'd4);
        chk("t1_p3_mask", obs_mask[3], 0);
        chk("t1_p3_coord", obs_coord[31:24], 8'hFF);
        chk("t1_last_wt", obs_lw, 8'd3);
        chk("t1_last_ip", obs_li, 8'd3);
        chk("t1_latency", emit_cyc - acc_cyc, 2);

        // Continuation: bases carry over to 4.
        send(1'b0, 4, 4, z, z);
        chk("t2_p0", obs_coord[7:0], 8'd4);
        chk("t2_last_wt", obs_lw, 8'd7);
        chk("t2_last_ip", obs_li, 8'd7);

        // Back-pressure: two fit in the pipe, the third waits.
        begin
            int n0, e0, seen, vi;
            n0 = acc_cnt; e0 = emit_cnt;
            out_ready = 1'b0;
            drive(1'b1, 4, 4, z, z);
            seen = acc_cnt; vi = 1;
            repeat (4) begin
                @(negedge clk);
                if (acc_cnt != seen && vi < 3) begin
                    drive(1'b1, 3, 2, z, z);
                    seen = acc_cnt; vi++;
                end
            end
            chk("stall_accepts", acc_cnt - n0, 2);
            chk("stall_in_ready", in_ready, 0);
            out_ready = 1'b1;
            wait_acc(seen);
            wait_emit(e0 + 3);
        end

        // Partial counts.
        cw = '0; cw[0] = 8'd1; cw[1] = 8'd2;
        send(1'b1, 2, 3, cw, z);
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < 4; i++)
                if (f >= 2 || i == 3) begin
                    chk("cnt_mask", obs_mask[f*4+i], 0);
                    chk("cnt_coord", obs_coord[(f*4+i)*8 +: 8], 8'hFF);
                end
        send(1'b0, 1, 1, z, z);
        chk("cnt_base_wt", obs_lw, 8'd5);
        chk("pre_ovf_err", err_ovf, 0);

        // Weight index past the 3x3 filter.
        cw = '0; cw[0] = 8'd8;
        send(1'b1, 4, 4, cw, z);
        chk("ovf_mask_hi", obs_mask[15:4], 0);
        chk("ovf_err", err_ovf, 1);
        send(1'b1, 4, 4, z, z);
        chk("ovf_sticky", err_ovf, 1);

        // Reset with both stages full.
        begin
            int n;
            out_ready = 1'b0;
            n = acc_cnt; drive(1'b1, 4, 4, z, z); wait_acc(n);
            n = acc_cnt; drive(1'b1, 4, 4, z, z); wait_acc(n);
            chk("full_out_valid", out_valid, 1);
            rst_n = 1'b0;
            q.delete(); m_bw = 0; m_bi = 0; m_err = 1'b0;
            #1;
            chk("mid_rst_valid", out_valid, 0);
            chk("mid_rst_err", err_ovf, 0);
            chk("mid_rst_mask", out_mask, 0);
            @(negedge clk);
            rst_n = 1'b1;
            out_ready = 1'b1;
            @(negedge clk);
            send(1'b0, 4, 4, z, z);
            chk("post_rst_base_wt", obs_lw, 8'd3);
            chk("post_rst_base_ip", obs_li, 8'd3);
        end

        // Random traffic under several geometries.
        for (int r = 0; r < 6; r++) begin
            cfg_wt_size = 4'($urandom_range(1, 5));
            cfg_ip_size = 8'($urandom_range(1, 16));
            rand_stream(40);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
